pipeline_controller: RTL and testbench

In-order issue controller for the 3-stage (IF/ID/EX) CPU: sits beside the instruction decoder and decides each cycle whether the decoded instruction in ID issues to EX, stalls, or is flushed. It keeps a 16-entry register scoreboard for RAW and WAW hazards, sequences multi-cycle MUL operations in EX, handles taken-branch flushes, and parks the pipeline on HALT.

---
 rtl/pipeline_controller.sv | 110 +++++++++++
 tb/tb_pipeline_controller.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/pipeline_controller.sv
// pipeline_controller: in-order IF/ID/EX issue control with a 16-entry scoreboard,
// multi-cycle MUL sequencing, branch flush and HALT parking.
module pipeline_controller #(
    parameter logic [3:0] MUL_OPCODE    = 4'hE,
    parameter int         MUL_LATENCY   = 4,
    parameter logic [3:0] NOP_OPCODE    = 4'h0,
    parameter logic [3:0] HALT_OPCODE   = 4'hF,
    parameter logic [3:0] BRANCH_OPCODE = 4'hC,
    parameter logic [3:0] STORE_OPCODE  = 4'hB
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [3:0]  id_opcode,
    input  logic [3:0]  id_reg1,
    input  logic [3:0]  id_reg2,
    input  logic [3:0]  id_dest,
    input  logic        wb_valid,
    input  logic [3:0]  wb_reg,
    input  logic        ex_branch_taken,
    output logic        issue,
    output logic        stall,
    output logic        flush,
    output logic        mul_busy,
    output logic        mul_done,
    output logic        halted,
    output logic [15:0] pending
);
    typedef enum logic [1:0] {RUN, MUL_BUSY, HALTED} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] wb_mask, eff;
    logic        src_used, has_dest, hazard;
    logic        issue_c, stall_c, flush_c, busy_c, done_c, halted_c;

    assign src_used = !(id_opcode == NOP_OPCODE || id_opcode == HALT_OPCODE);
    assign has_dest = src_used && !(id_opcode == BRANCH_OPCODE || id_opcode == STORE_OPCODE);
    assign wb_mask  = wb_valid ? (16'b1 << wb_reg) : 16'b0;
    assign eff      = pending_q & ~wb_mask;
    assign hazard   = src_used && (eff[id_reg1] || eff[id_reg2] || (has_dest && eff[id_dest]));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        issue_c  = 1'b0;
        stall_c  = 1'b0;
        flush_c  = 1'b0;
        busy_c   = 1'b0;
        done_c   = 1'b0;
        halted_c = 1'b0;
        case (state_q)
            RUN: begin
                if (ex_branch_taken) begin
                    flush_c = 1'b1;
                end else if (id_valid) begin
                    if (hazard) begin
                        stall_c = 1'b1;
                    end else if (id_opcode == HALT_OPCODE) begin
                        // a same-cycle writeback of the last outstanding register lets HALT go now
                        issue_c = (eff == 16'b0);
                        stall_c = (eff != 16'b0);
                        state_d = (eff == 16'b0) ? HALTED : RUN;
                    end else begin
                        issue_c = 1'b1;
                        if (id_opcode == MUL_OPCODE) begin
                            cnt_d   = 4'(MUL_LATENCY - 1);
                            state_d = MUL_BUSY;
                        end
                    end
                end
            end
            MUL_BUSY: begin
                busy_c  = 1'b1;
                stall_c = 1'b1;
                done_c  = (cnt_q == 4'd0);
                cnt_d   = (cnt_q == 4'd0) ? 4'd0 : cnt_q - 4'd1;
                state_d = (cnt_q == 4'd0) ? RUN : MUL_BUSY;
            end
            HALTED: begin
                halted_c = 1'b1;
                stall_c  = 1'b1;
            end
            default: state_d = RUN;
        endcase
        pending_d = eff | ((issue_c && has_dest) ? (16'b1 << id_dest) : 16'b0);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            cnt_q     <= 4'd0;
            pending_q <= 16'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
        end
    end

    // outputs are forced low for the whole time reset is held, not just after the next edge
    assign issue    = rst & issue_c;
    assign stall    = rst & stall_c;
    assign flush    = rst & flush_c;
    assign mul_busy = rst & busy_c;
    assign mul_done = rst & done_c;
    assign halted   = rst & halted_c;
    assign pending  = pending_q;
endmodule

// File: tb/tb_pipeline_controller.sv
// tb_pipeline_controller: directed vectors for hazards, MUL timing, flush, HALT and reset.
module tb_pipeline_controller;
    localparam logic [5:0] ISS = 6'b100000, STL = 6'b010000, FLS = 6'b001000;
    localparam logic [5:0] MB = 6'b000100, MD = 6'b000010, HLT = 6'b000001, NONE = 6'b000000;

    logic        clk = 1'b0, rst = 1'b0;
    logic        id_valid = 1'b0, wb_valid = 1'b0, ex_branch_taken = 1'b0;
    logic [3:0]  id_opcode = 4'h0, id_reg1 = 4'h0, id_reg2 = 4'h0, id_dest = 4'h0, wb_reg = 4'h0;
    logic        issue, stall, flush, mul_busy, mul_done, halted;
    logic [15:0] pending;
    logic [5:0]  ctl;
    int          checks = 0, errors = 0;

    assign ctl = {issue, stall, flush, mul_busy, mul_done, halted};

    pipeline_controller dut (
        .clk(clk), .rst(rst),
        .id_valid(id_valid), .id_opcode(id_opcode), .id_reg1(id_reg1), .id_reg2(id_reg2),
        .id_dest(id_dest), .wb_valid(wb_valid), .wb_reg(wb_reg),
        .ex_branch_taken(ex_branch_taken),
        .issue(issue), .stall(stall), .flush(flush), .mul_busy(mul_busy),
        .mul_done(mul_done), .halted(halted), .pending(pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [3:0] r1,
                         input logic [3:0] r2, input logic [3:0] d, input logic wv,
                         input logic [3:0] wr, input logic br);
        id_valid = v; id_opcode = op; id_reg1 = r1; id_reg2 = r2; id_dest = d;
        wb_valid = wv; wb_reg = wr; ex_branch_taken = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1, 4'h1, 4'd1, 4'd2, 4'd3, 0, 4'd0, 0);
        check("reset_ctl", 32'(ctl), 32'(NONE));
        check("reset_pend", 32'(pending), 32'h0);
        tick();
        rst = 1'b1;
        // RAW on R3, then write-through release
        drive(1, 4'h1, 4'd1, 4'd2, 4'd3, 0, 4'd0, 0);
        check("add_issue", 32'(ctl), 32'(ISS));
        tick();
        check("pend_r3", 32'(pending), 32'h0008);
        drive(1, 4'h2, 4'd3, 4'd4, 4'd6, 0, 4'd0, 0);
        check("raw_stall", 32'(ctl), 32'(STL));
        tick();
        check("raw_hold", 32'(pending), 32'h0008);
        drive(1, 4'h2, 4'd3, 4'd4, 4'd6, 1, 4'd3, 0);
        check("wt_issue", 32'(ctl), 32'(ISS));
        tick();
        check("pend_r6", 32'(pending), 32'h0040);
        // set/clear collision on R2
        drive(1, 4'h1, 4'd0, 4'd1, 4'd2, 1, 4'd2, 0);
        check("coll_issue", 32'(ctl), 32'(ISS));
        tick();
        check("coll_pend", 32'(pending), 32'h0044);
        drive(1, 4'h1, 4'd0, 4'd1, 4'd2, 1, 4'd2, 0);
        check("waw_wt_issue", 32'(ctl), 32'(ISS));
        tick();
        check("coll_pend2", 32'(pending), 32'h0044);
        // flush priority
        drive(1, 4'h1, 4'd1, 4'd1, 4'd9, 0, 4'd0, 1);
        check("flush_clean", 32'(ctl), 32'(FLS));
        tick();
        check("flush_pend", 32'(pending), 32'h0044);
        drive(1, 4'h2, 4'd6, 4'd1, 4'd10, 0, 4'd0, 1);
        check("flush_hazard", 32'(ctl), 32'(FLS));
        tick();
        drive(0, 4'h0, 4'd0, 4'd0, 4'd0, 1, 4'd6, 0);
        check("idle", 32'(ctl), 32'(NONE));
        tick();
        drive(0, 4'h0, 4'd0, 4'd0, 4'd0, 1, 4'd2, 0);
        tick();
        check("pend_clear", 32'(pending), 32'h0);
        // MUL sequencing
        drive(1, 4'hE, 4'd1, 4'd1, 4'd5, 0, 4'd0, 0);
        check("mul_issue", 32'(ctl), 32'(ISS));
        tick();
        check("mul_pend", 32'(pending), 32'h0020);
        for (int i = 1; i <= 4; i++) begin
            drive(1, 4'h1, 4'd1, 4'd1, 4'd8, 0, 4'd0, i == 2);
            check($sformatf("mul_busy_%0d", i), 32'(ctl), 32'(STL | MB | ((i == 4) ? MD : NONE)));
            tick();
        end
        drive(1, 4'h1, 4'd1, 4'd1, 4'd8, 0, 4'd0, 0);
        check("post_mul_issue", 32'(ctl), 32'(ISS));
        tick();
        check("post_mul_pend", 32'(pending), 32'h0120);
        drive(0, 4'h0, 4'd0, 4'd0, 4'd0, 1, 4'd5, 0);
        tick();
        drive(0, 4'h0, 4'd0, 4'd0, 4'd0, 1, 4'd8, 0);
        tick();
        check("pend_clear2", 32'(pending), 32'h0);
        // reset mid-MUL
        drive(1, 4'hE, 4'd1, 4'd1, 4'd5, 0, 4'd0, 0);
        check("mul2_issue", 32'(ctl), 32'(ISS));
        tick();
        tick();
        check("mul2_busy", 32'(ctl), 32'(STL | MB));
        rst = 1'b0;
        #1;
        check("async_rst_ctl", 32'(ctl), 32'(NONE));
        check("async_rst_pend", 32'(pending), 32'h0);
        rst = 1'b1;
        drive(1, 4'h1, 4'd1, 4'd1, 4'd7, 0, 4'd0, 0);
        check("rst_run_issue", 32'(ctl), 32'(ISS));
        tick();
        check("pend_r7", 32'(pending), 32'h0080);
        // HALT waits for R7, then parks
        drive(1, 4'hF, 4'd0, 4'd0, 4'd0, 0, 4'd0, 0);
        check("halt_stall", 32'(ctl), 32'(STL));
        tick();
        drive(1, 4'hF, 4'd0, 4'd0, 4'd0, 1, 4'd7, 0);
        check("halt_issue", 32'(ctl), 32'(ISS));
        tick();
        for (int i = 0; i < 20; i++) begin
            drive(1, 4'h1, 4'd1, 4'd2, 4'd3, 0, 4'd0, 1);
            check($sformatf("halted_%0d", i), 32'(ctl), 32'(STL | HLT));
            tick();
        end
        check("halted_pend", 32'(pending), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
